// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow complete on a one-cycle fast path.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_Clock,
  input  logic             i_Reset_n,
  input  logic             i_Start,
  input  logic [1:0]       i_DivOp,
  input  logic [WIDTH-1:0] i_Dividend,
  input  logic [WIDTH-1:0] i_Divisor,
  input  logic             i_Flush,
  output logic             o_Ready,
  output logic             o_Busy,
  output logic             o_Valid,
  output logic [WIDTH-1:0] o_Result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP, DONE} state_t;

  state_t            state, stateNext;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  rem, quo, dvsr, result;
  logic              negQ, negR, isRem;

  logic              accept, isSigned, divByZero, overflow;
  logic [WIDTH:0]    trial;

  function automatic logic [WIDTH-1:0] negate(input logic signed [WIDTH-1:0] v);
    negate = -v;
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    magnitude = (v < 0) ? negate(v) : v;
  endfunction

  assign accept    = i_Start && (state == IDLE) && !i_Flush;
  assign isSigned  = ~i_DivOp[0];
  assign divByZero = (i_Divisor == '0);
  assign overflow  = isSigned && (i_Dividend == MIN_NEG) && (i_Divisor == '1);

  // Trial subtraction on the shifted partial remainder; bit WIDTH is the borrow.
  assign trial = {rem, quo[WIDTH-1]} - {1'b0, dvsr};

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) state <= IDLE;
    else            state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    o_Ready   = 1'b0;
    o_Busy    = 1'b0;
    o_Valid   = 1'b0;
    case (state)
      IDLE: begin
        o_Ready = 1'b1;
        if (accept) stateNext = (divByZero || overflow) ? DONE : DIVIDE;
      end
      DIVIDE: begin
        o_Busy = 1'b1;
        if (i_Flush)          stateNext = IDLE;
        else if (cnt == '0)   stateNext = FIXUP;
      end
      FIXUP: begin
        o_Busy    = 1'b1;
        stateNext = i_Flush ? IDLE : DONE;
      end
      DONE: begin
        o_Valid   = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      result <= '0;
      negQ   <= 1'b0;
      negR   <= 1'b0;
      isRem  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (divByZero) begin
              result <= i_DivOp[1] ? i_Dividend : '1;
            end else if (overflow) begin
              result <= i_DivOp[1] ? '0 : MIN_NEG;
            end else begin
              rem   <= '0;
              quo   <= isSigned ? magnitude(i_Dividend) : i_Dividend;
              dvsr  <= isSigned ? magnitude(i_Divisor)  : i_Divisor;
              cnt   <= CNT_LAST;
              negQ  <= isSigned && (i_Dividend[WIDTH-1] ^ i_Divisor[WIDTH-1]);
              negR  <= isSigned && i_Dividend[WIDTH-1];
              isRem <= i_DivOp[1];
            end
          end
        end
        // One quotient bit per cycle; keep the shifted remainder when the trial borrows.
        DIVIDE: begin
          if (!i_Flush) begin
            rem <= trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
            if (cnt != '0) cnt <= cnt - 1'b1;
          end
        end
        FIXUP: begin
          if (!i_Flush) begin
            if (isRem) result <= negR ? negate(rem) : rem;
            else       result <= negQ ? negate(quo) : quo;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_Result = result;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
- Sits beside the single-cycle ALU in the execute stage.
- Takes operands with a start/ready handshake and returns one 32-bit result after a fixed multi-cycle latency.
- Divide-by-zero and signed-overflow cases finish on a fast path.

Parameters:
- WIDTH, 32, operand and result width in bits. The iteration count equals WIDTH.

Ports:
- i_Clock  input  1  single clock; all state updates on rising edge
- i_Reset_n  input  1  asynchronous, active-low reset
- i_Start  input  1  request; accepted on an edge where i_Start && o_Ready
- i_DivOp  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU; sampled at accept
- i_Dividend  input  WIDTH  rs1; sampled at accept
- i_Divisor  input  WIDTH  rs2; sampled at accept
- i_Flush  input  1  abort the in-flight operation (pipeline kill)
- o_Ready  output  1  high only in IDLE
- o_Busy  output  1  high in DIVIDE or FIXUP
- o_Valid  output  1  one-cycle pulse; o_Result is valid while it is high
- o_Result  output  WIDTH  quotient or remainder; holds its last value until the next o_Valid

Behaviour:
- Reset (asynchronous, i_Reset_n=0) applies at any time, including mid-operation, and gives:
  - state=IDLE
  - o_Ready=1, o_Busy=0, o_Valid=0
  - o_Result=0
  - counter, remainder and quotient registers all 0
- States: IDLE, DIVIDE, FIXUP, DONE.
- IDLE, on accept:
  - Divisor==0 → DONE. Result is 0xFFFFFFFF for DIV/DIVU; the unmodified dividend for REM/REMU.
  - Signed op with dividend==0x80000000 and divisor==0xFFFFFFFF → DONE. Result is 0x80000000 for DIV; 0 for REM.
  - Otherwise latch magnitudes:
    - Signed ops: two's-complement abs of each operand.
    - Unsigned ops: raw operands.
    - Also latch negQ = sign(a) XOR sign(b) and negR = sign(a), both signed ops only.
    - Then clear the remainder, set counter=WIDTH-1 and go to DIVIDE.
- DIVIDE, one iteration per cycle:
  - Shift {rem, quo} left by 1.
  - Compute trial = rem_shifted − divisor as a WIDTH+1-bit value.
  - If trial is non-negative, rem = trial[WIDTH-1:0] and the new quotient LSB is 1; otherwise the LSB is 0.
  - At counter==0 go to FIXUP; otherwise decrement the counter.
- FIXUP:
  - Negate the quotient if negQ; negate the remainder if negR.
  - Select the quotient (DIV/DIVU) or remainder (REM/REMU) into o_Result.
  - Go to DONE.
- DONE: o_Valid=1 for exactly one cycle, then unconditionally → IDLE. i_Start is ignored in DONE (o_Ready=0).
- Latency, counting the accept edge as edge 0:
  - Normal ops: WIDTH iterations end at edge WIDTH; FIXUP→DONE at edge WIDTH+1; o_Valid is high in the cycle after edge WIDTH+1 (34 cycles for WIDTH=32). The minimum issue interval is WIDTH+3 cycles.
  - Fast path: o_Valid is high in the cycle after edge 0. The issue interval is 2 cycles.
- i_Flush:
  - In DIVIDE or FIXUP: → IDLE at the next edge, no o_Valid produced, o_Result unchanged.
  - In DONE: suppression is not required; the pulse still occurs.
  - In IDLE: no effect.
  - Flush has priority over accept on the same edge: no accept occurs.
- Sign rule: the remainder takes the dividend's sign, and quotient × divisor + remainder == dividend (mod 2^WIDTH) for all non-special cases.
- Operand inputs may change freely after the accept edge without affecting the result.

Test Plan:
- DIVU 100/7 → o_Result=14 after 34 cycles; REMU 100/7 → 2; o_Valid high exactly 1 cycle; o_Busy high for 33 cycles.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD (−3); REM → 0xFFFFFFFF (−1); also DIV 7/0xFFFFFFFE → 0xFFFFFFFD and REM → 1.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF, REM 5/0 → 5, o_Valid in the cycle after accept; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0, same latency.
- Assert i_Flush during iteration 10 → no o_Valid ever for that op, o_Ready=1 next cycle; start DIVU 9/3 in the following cycle → result 3.
- Hold i_Start high through a full op → second op accepted only when o_Ready returns; change operands after accept → result reflects the latched values.
- Pull i_Reset_n low asynchronously mid-DIVIDE → o_Valid=0, o_Busy=0, o_Ready=1, o_Result=0 immediately; no stale o_Valid after release.
